// File: rtl/det_share_arbiter.sv
// Round-robin share of one serial pattern detector: grant, shift word MSB-first, flush, report match.
// Latency: grant the cycle after req is sampled, done W+2 cycles after the pick; no backpressure on results.
module det_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*W-1:0]    data,
    output logic [NREQ-1:0]      grant,
    output logic                 det_rst,
    output logic                 det_bit,
    input  logic                 det_z,
    output logic                 done,
    output logic                 match,
    output logic [IDW-1:0]       done_id
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  idx_q, idx_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hit_q, hit_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            det_rst_q, det_rst_d;
    logic            det_bit_q, det_bit_d;
    logic            done_q, done_d;
    logic            match_q, match_d;
    logic [IDW-1:0]  done_id_q, done_id_d;

    logic            pick_vld;
    logic [IDW-1:0]  pick_idx;
    logic [IDW:0]    cand;
    logic [W-1:0]    pick_word;

    // First requester at or above rr, wrapping at NREQ-1.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
            if (!pick_vld && req[cand[IDW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDW-1:0];
            end
        end
    end

    assign pick_word = data[int'(pick_idx)*W +: W];

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        grant_d   = grant_q;
        det_rst_d = det_rst_q;
        det_bit_d = det_bit_q;
        done_d    = 1'b0;
        match_d   = 1'b0;
        done_id_d = done_id_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d   = SHIFT;
                    idx_d     = pick_idx;
                    det_bit_d = pick_word[W-1];
                    shreg_d   = {pick_word[W-2:0], 1'b0};
                    grant_d   = NREQ'(1) << pick_idx;
                    det_rst_d = 1'b0;
                    cnt_d     = '0;
                    hit_d     = 1'b0;
                end
            end
            SHIFT: begin
                hit_d = hit_q | det_z;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) begin
                    state_d   = FLUSH;
                    det_bit_d = 1'b0;
                end else begin
                    det_bit_d = shreg_q[W-1];
                    shreg_d   = {shreg_q[W-2:0], 1'b0};
                end
            end
            FLUSH: begin
                // z lags its input bit by a clock, so the last bit's result only shows up here.
                hit_d     = hit_q | det_z;
                state_d   = DONE;
                done_d    = 1'b1;
                match_d   = hit_q | det_z;
                done_id_d = idx_q;
                det_rst_d = 1'b1;
                det_bit_d = 1'b0;
            end
            DONE: begin
                state_d   = IDLE;
                grant_d   = '0;
                det_rst_d = 1'b1;
                rr_d      = (idx_q == IDW'(NREQ-1)) ? '0 : idx_q + IDW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            grant_q   <= '0;
            det_rst_q <= 1'b1;
            det_bit_q <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            grant_q   <= grant_d;
            det_rst_q <= det_rst_d;
            det_bit_q <= det_bit_d;
            done_q    <= done_d;
            match_q   <= match_d;
            done_id_q <= done_id_d;
        end
    end

    assign grant   = grant_q;
    assign det_rst = det_rst_q;
    assign det_bit = det_bit_q;
    assign done    = done_q;
    assign match   = match_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_det_share_arbiter.sv
// Bench for det_share_arbiter: "1100" Moore detector, transaction-level reference model, directed and random stimulus.
module tb_det_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*W-1:0]    data;
    logic [NREQ-1:0]      grant;
    logic                 det_rst, det_bit, det_z, done, match;
    logic [IDW-1:0]       done_id;

    int checks   = 0;
    int failures = 0;

    det_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .grant(grant),
        .det_rst(det_rst), .det_bit(det_bit), .det_z(det_z),
        .done(done), .match(match), .done_id(done_id)
    );

    always #5 clk = ~clk;

    // Shared detector: Moore, z=1 once the last four received bits are 1,1,0,0.
    logic [3:0] hist;
    always_ff @(posedge clk or posedge det_rst) begin
        if (det_rst) hist <= 4'b0000;
        else         hist <= {hist[2:0], det_bit};
    end
    assign det_z = (hist == 4'b1100);

    function automatic bit has1100(input logic [W-1:0] w);
        for (int p = 0; p <= W-4; p++)
            if (w[p+3 -: 4] == 4'b1100) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: t runs 0..W-1 shifting, W flushing, W+1 reporting.
    bit           m_busy = 1'b0;
    int           m_t    = 0;
    int           m_idx  = 0;
    int           m_rr   = 0;
    int           m_c;
    bit           m_found;
    logic [W-1:0] m_word = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_rr   = 0;
            m_t    = 0;
        end else if (m_busy) begin
            if (m_t == W+1) begin
                m_busy = 1'b0;
                m_rr   = (m_idx + 1) % NREQ;
            end else begin
                m_t++;
            end
        end else if (req != '0) begin
            m_found = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                m_c = (m_rr + i) % NREQ;
                if (!m_found && req[m_c]) begin
                    m_found = 1'b1;
                    m_idx   = m_c;
                end
            end
            m_busy = 1'b1;
            m_t    = 0;
            m_word = data[m_idx*W +: W];
        end
    end

    // Per-transaction records observed from the DUT.
    int           rec_id[$];
    bit           rec_match[$];
    logic [W-1:0] rec_bits[$];
    int           rec_gcyc[$];
    logic [W-1:0] col_bits = '0;
    int           col_n = 0;
    int           g_n = 0;

    logic [NREQ-1:0] exp_grant;
    logic            exp_rst, exp_bit, exp_done;

    always @(negedge clk) begin
        if (!reset) begin
            exp_grant = m_busy ? NREQ'(1) << m_idx : '0;
            exp_rst   = !(m_busy && m_t <= W);
            exp_bit   = (m_busy && m_t < W) ? m_word[W-1-m_t] : 1'b0;
            exp_done  = m_busy && (m_t == W+1);
            chk("grant", 32'(grant), 32'(exp_grant));
            chk("det_rst", 32'(det_rst), 32'(exp_rst));
            chk("det_bit", 32'(det_bit), 32'(exp_bit));
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                chk("match", 32'(match), 32'(has1100(m_word)));
                chk("done_id", 32'(done_id), 32'(m_idx));
            end
        end
        if (reset || grant == '0) begin
            col_n = 0;
            g_n   = 0;
        end else begin
            g_n++;
            if (!det_rst && col_n < W) begin
                col_bits = {col_bits[W-2:0], det_bit};
                col_n++;
            end
            if (done) begin
                rec_id.push_back(int'(done_id));
                rec_match.push_back(match);
                rec_bits.push_back(col_bits);
                rec_gcyc.push_back(g_n);
            end
        end
    end

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (grant != '0) ok = 1'b1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL grant_timeout: no grant within 40 cycles");
        end
    endtask

    task automatic wait_recs(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 120 && !ok; i++) begin
            @(negedge clk); #1;
            if (rec_id.size() >= target) ok = 1'b1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL done_timeout: have %0d records, need %0d", rec_id.size(), target);
        end
    endtask

    task automatic txn(input logic [NREQ-1:0] r, input int id_exp,
                       input logic [W-1:0] bits_exp, input bit m_exp);
        int n0;
        bit ok;
        n0 = rec_id.size();
        @(negedge clk);
        req = r;
        wait_grant(ok);
        req = '0;
        wait_recs(n0 + 1, ok);
        if (ok) begin
            chk("txn_id", 32'(rec_id[n0]), 32'(id_exp));
            chk("txn_match", 32'(rec_match[n0]), 32'(m_exp));
            chk("txn_bits", 32'(rec_bits[n0]), 32'(bits_exp));
            chk("txn_grant_cycles", 32'(rec_gcyc[n0]), 32'd10);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n0;
        bit ok;
        int exp_ids[5];
        exp_ids = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        req   = '0;
        data  = '0;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_det_rst", 32'(det_rst), 32'd1);
        chk("rst_det_bit", 32'(det_bit), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        data[0*W +: W] = 8'hC0;
        txn(4'b0001, 0, 8'hC0, 1'b1);
        data[1*W +: W] = 8'hA5;
        txn(4'b0010, 1, 8'hA5, 1'b0);
        data[2*W +: W] = 8'hFC;
        txn(4'b0100, 2, 8'hFC, 1'b1);

        // All four requesting continuously from reset.
        do_reset();
        data = '0;
        n0 = rec_id.size();
        req = 4'b1111;
        wait_recs(n0 + 5, ok);
        req = '0;
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                chk("rr_order", 32'(rec_id[n0+i]), 32'(exp_ids[i]));
                chk("rr_match", 32'(rec_match[n0+i]), 32'd0);
            end
        end
        repeat (3) @(negedge clk);

        // Data and req change after grant must not disturb the word in flight.
        data[0*W +: W] = 8'hC0;
        n0 = rec_id.size();
        req = 4'b0001;
        wait_grant(ok);
        repeat (2) @(negedge clk);
        data[0*W +: W] = 8'h00;
        req = '0;
        wait_recs(n0 + 1, ok);
        if (ok) begin
            chk("capture_match", 32'(rec_match[n0]), 32'd1);
            chk("capture_bits", 32'(rec_bits[n0]), 32'hC0);
            chk("capture_id", 32'(rec_id[n0]), 32'd0);
        end
        repeat (2) @(negedge clk);

        // Reset in the middle of shifting.
        data[0*W +: W] = 8'hC0;
        req = 4'b0001;
        wait_grant(ok);
        repeat (3) @(negedge clk);
        n0 = rec_id.size();
        reset = 1'b1;
        req   = '0;
        #1;
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_det_rst", 32'(det_rst), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrst_no_done", 32'(rec_id.size()), 32'(n0));
        txn(4'b0001, 0, 8'hC0, 1'b1);

        // Random traffic checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if ($urandom_range(0, 2) == 0)
                for (int i = 0; i < NREQ; i++) data[i*W +: W] = W'($urandom);
        end
        req = '0;
        repeat (15) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
